// File: rtl/companion_action_exec.sv
// Companion action executor: runs a timed Feed/Play/Clean action on request
// from the menu FSM and owns the pet stat registers with their periodic decay.
module companion_action_exec #(
  parameter int STAT_W       = 4,
  parameter int TICK_DIV     = 50000000,
  parameter int ACTION_TICKS = 8,
  parameter int DECAY_TICKS  = 16,
  parameter int FEED_AMT     = 4,
  parameter int PLAY_AMT     = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  exec,
  input  logic [1:0]                            selected,
  output logic                                  exec_status,
  output logic                                  busy,
  output logic [$clog2(ACTION_TICKS+1)-1:0]     progress,
  output logic [STAT_W-1:0]                     hunger,
  output logic [STAT_W-1:0]                     happiness,
  output logic [STAT_W-1:0]                     cleanliness
);

  localparam int PW = $clog2(ACTION_TICKS + 1);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DECAY_TICKS > 1) ? $clog2(DECAY_TICKS) : 1;
  localparam int unsigned SMAX_I = (2 ** STAT_W) - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [1:0]      act;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   dcnt;
  logic            tick;
  logic            decay_wrap;
  logic            last_tick;

  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] v,
                                                input int unsigned a);
    int unsigned s;
    s = 32'(v) + a;
    if (s > SMAX_I) return '1;
    return s[STAT_W-1:0];
  endfunction

  function automatic logic [STAT_W-1:0] sat_sub(input logic [STAT_W-1:0] v,
                                                input int unsigned a);
    int unsigned s;
    if (32'(v) < a) return '0;
    s = 32'(v) - a;
    return s[STAT_W-1:0];
  endfunction

  always_comb begin
    tick       = (cnt == CW'(TICK_DIV - 1));
    decay_wrap = (dcnt == DW'(DECAY_TICKS - 1));
    last_tick  = (progress == PW'(ACTION_TICKS - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt <= '0;
    else      cnt <= tick ? '0 : cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      act         <= 2'b00;
      exec_status <= 1'b0;
      busy        <= 1'b0;
      progress    <= '0;
      dcnt        <= '0;
      hunger      <= '0;
      happiness   <= '1;
      cleanliness <= '1;
    end else begin
      // Decay only outside RUN, so it can never collide with an effect update.
      if (tick && state != RUN) begin
        if (decay_wrap) begin
          dcnt        <= '0;
          hunger      <= sat_add(hunger, 1);
          happiness   <= sat_sub(happiness, 1);
          cleanliness <= sat_sub(cleanliness, 1);
        end else begin
          dcnt <= dcnt + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (exec && selected != 2'b00) begin
            act      <= selected;
            progress <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (!exec) begin
            busy     <= 1'b0;
            progress <= '0;
            state    <= IDLE;
          end else if (tick) begin
            if (last_tick) begin
              progress    <= PW'(ACTION_TICKS);
              busy        <= 1'b0;
              exec_status <= 1'b1;
              state       <= DONE;
              case (act)
                2'b01: hunger <= sat_sub(hunger, FEED_AMT);
                2'b10: begin
                  happiness   <= sat_add(happiness, PLAY_AMT);
                  cleanliness <= sat_sub(cleanliness, 1);
                end
                2'b11: cleanliness <= '1;
                default: ;
              endcase
            end else begin
              progress <= progress + 1'b1;
            end
          end
        end
        DONE: begin
          if (!exec) begin
            exec_status <= 1'b0;
            progress    <= '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/companion_action_exec.md
Name: companion_action_exec

Overview:
- Executes the action the companion menu FSM commits: Feed, Play or Clean.
- Takes the menu FSM's `exec` level and `selected` code, runs a timed action and applies its effect to the pet stats.
- Returns `exec_status` so the menu FSM can leave its Exec state.
- Owns the pet stat registers and their slow decay over time.

Parameters:
- STAT_W, 4: width of each stat register; max stat value SMAX = 2^STAT_W-1.
- TICK_DIV, 50000000: clk cycles per game tick; must be >= 2.
- ACTION_TICKS, 8: game ticks an action lasts; must be >= 1.
- DECAY_TICKS, 16: game ticks between stat decay steps; must be >= 1.
- FEED_AMT, 4: hunger reduction per Feed.
- PLAY_AMT, 3: happiness increase per Play.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- exec  in  1  action request level from the menu FSM.
- selected  in  2  action code: 00 none, 01 Feed, 10 Play, 11 Clean.
- exec_status  out  1  action-complete level back to the menu FSM.
- busy  out  1  high while an action is running.
- progress  out  clog2(ACTION_TICKS+1)  completed ticks of the current action.
- hunger  out  STAT_W  0 = full, SMAX = starving.
- happiness  out  STAT_W  SMAX = happiest.
- cleanliness  out  STAT_W  SMAX = spotless.

Behaviour:
- Reset (rst low, asynchronous): FSM IDLE, exec_status 0, busy 0, progress 0, prescaler 0, decay counter 0, hunger 0, happiness SMAX, cleanliness SMAX, latched action 00.
- Prescaler: free-running 0..TICK_DIV-1. `tick` is high for the single cycle in which count = TICK_DIV-1, then count wraps to 0.
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - exec=1 and selected!=00: latch selected, clear progress, go to RUN.
  - exec=1 and selected=00: ignored, stay in IDLE.
- RUN:
  - busy=1.
  - The latched action is used; changes on `selected` are ignored.
  - Each tick increments progress.
  - On the tick that makes progress = ACTION_TICKS: apply the effect in the same edge and go to DONE.
  - A tick in the same cycle as the IDLE->RUN transition is not counted.
  - exec=0 while in RUN (abort): go to IDLE next edge; no effect applied, progress cleared, exec_status stays 0.
- DONE:
  - exec_status=1, busy=0, progress holds at ACTION_TICKS.
  - exec_status stays high while exec=1.
  - When exec=0: go to IDLE, exec_status drops and progress clears on the same edge.
- Effects (all saturating, no wrap):
  - Feed: hunger = max(hunger-FEED_AMT, 0).
  - Play: happiness = min(happiness+PLAY_AMT, SMAX); cleanliness = max(cleanliness-1, 0).
  - Clean: cleanliness = SMAX.
- Decay:
  - The decay counter advances on each tick while in IDLE or DONE; it is frozen in RUN.
  - On the tick where counter = DECAY_TICKS-1: counter wraps to 0, hunger +1 (saturate at SMAX), happiness -1 (saturate at 0), cleanliness -1 (saturate at 0).
- Decay and effect can never coincide, since effects apply only on the RUN->DONE edge and decay is frozen in RUN.
- Latency: DONE is entered between (ACTION_TICKS-1)*TICK_DIV+1 and ACTION_TICKS*TICK_DIV cycles after the IDLE->RUN edge, depending on prescaler phase.

Test Plan (TICK_DIV=4, ACTION_TICKS=3, DECAY_TICKS=8, STAT_W=4, FEED_AMT=4, PLAY_AMT=3):
1. Reset asserted mid-RUN -> all outputs return immediately (asynchronous) to: exec_status 0, busy 0, progress 0, hunger 0, happiness 15, cleanliness 15.
2. Idle 5 decay periods (160 cycles), then exec=1 with selected=01:
   - Before the action: hunger 5, happiness 10, cleanliness 10.
   - busy high for 9..12 cycles, progress steps 1,2,3.
   - At completion: exec_status=1, hunger 1.
   - exec held 20 more cycles -> exec_status stays 1 and no decay step fires (counter < 7).
   - exec=0 -> IDLE next edge, exec_status 0.
3. From reset, Play -> happiness saturates at 15 (not 2), cleanliness 14. Then Feed -> hunger stays 0.
4. Start Clean, drop exec after 5 cycles -> IDLE, exec_status never rises, cleanliness unchanged.
5. exec=1 with selected=00 for 50 cycles -> busy stays 0, exec_status stays 0; decay still runs.
6. Start Feed, change selected to 11 mid-RUN -> Feed effect applied, cleanliness unchanged.
